alu_seq: RTL and testbench

Parametrised, clocked successor to the team's 8-bit accumulator ALU. It executes one operation per `start` request on `WIDTH`-bit `ac`/`dr` operands and returns a registered result with carry/zero flags. A `start`/`busy`/`done` handshake replaces the edge-triggered `activate` strobe. An optional iterative shift-add multiplier is the only multi-cycle operation. The block sits between the control unit, which issues `start` with a mode, and the accumulator/data-register file.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and alu_seq.
// The master drives the operation request; the slave returns the registered result and flags.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] dr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             e;
  logic             z;
  logic             err;

  modport master (
    output start, mode, ac, dr,
    input  busy, done, result, e, z, err
  );

  modport slave (
    input  start, mode, ac, dr,
    output busy, done, result, e, z, err
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked accumulator ALU: one operation per start, registered result with carry/zero flags.
// Optional iterative shift-add multiplier compiled in with `define ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus_io
);

  logic             start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] dr;

  assign start = bus_io.start;
  assign mode  = bus_io.mode;
  assign ac    = bus_io.ac;
  assign dr    = bus_io.dr;

  logic [WIDTH-1:0] result_q, result_d;
  logic             e_q, e_d;
  logic             z_q, z_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             idle;

  // Single-cycle operation decode
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   neg_sum;
  logic [WIDTH-1:0] op_res;
  logic             op_e;
  logic             op_legal;
`ifdef ALU_SEQ_MUL_EN
  logic             op_mul;
`endif

  always_comb begin
    add_sum  = {1'b0, ac} + {1'b0, dr};
    neg_sum  = {1'b0, ~ac} + {{WIDTH{1'b0}}, 1'b1};
    op_res   = '0;
    op_e     = 1'b0;
    op_legal = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    op_mul   = 1'b0;
`endif
    case (mode)
      3'b000: begin
        op_res = add_sum[WIDTH-1:0];
        op_e   = add_sum[WIDTH];
      end
      3'b001: begin
        op_res = {dr[WIDTH-2:0], 1'b0};
        op_e   = dr[WIDTH-1];
      end
      3'b010: op_res = ~(ac ^ dr);
      3'b011: begin
        op_res = {1'b0, dr[WIDTH-1:1]};
        op_e   = dr[0];
      end
      3'b100: op_res = dr;
      3'b110: begin
        op_res = neg_sum[WIDTH-1:0];
        op_e   = neg_sum[WIDTH];
      end
`ifdef ALU_SEQ_MUL_EN
      3'b101: op_mul = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [0:0] {StIdle, StMul} state_e;

  localparam logic [WIDTH-1:0] LastCnt = WIDTH'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;

  // Product register holds {partial sum, remaining multiplier bits}; shifts right each step
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign prod_step = prod_q[0] ? {step_sum, prod_q[WIDTH-1:1]}
                               : {1'b0, prod_q[2*WIDTH-1:1]};
  assign idle      = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end
`else
  assign idle = 1'b1;
`endif

  always_comb begin
    result_d = result_q;
    e_d      = e_q;
    z_d      = z_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
`endif
    if (start && idle) begin
`ifdef ALU_SEQ_MUL_EN
      if (op_mul) begin
        state_d = StMul;
        cnt_d   = '0;
        mcand_d = ac;
        prod_d  = {{WIDTH{1'b0}}, dr};
      end else
`endif
      if (op_legal) begin
        result_d = op_res;
        e_d      = op_e;
        z_d      = (op_res == '0);
        done_d   = 1'b1;
      end else begin
        done_d   = 1'b1;
        err_d    = 1'b1;
      end
    end
`ifdef ALU_SEQ_MUL_EN
    if (state_q == StMul) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        result_d = prod_step[WIDTH-1:0];
        e_d      = |prod_step[2*WIDTH-1:WIDTH];
        z_d      = (prod_step[WIDTH-1:0] == '0);
        done_d   = 1'b1;
        cnt_d    = '0;
        state_d  = StIdle;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      e_q      <= 1'b0;
      z_q      <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      e_q      <= e_d;
      z_q      <= z_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.busy   = ~idle;
  assign bus_io.done   = done_q;
  assign bus_io.err    = err_q;
  assign bus_io.result = result_q;
  assign bus_io.e      = e_q;
  assign bus_io.z      = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: vector table for single-cycle ops plus
// hand-written back-to-back, multiply and abort sequences (multiply parts need ALU_SEQ_MUL_EN).
module tb_alu_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0] mode;
    logic [7:0] ac;
    logic [7:0] dr;
    logic [7:0] res;
    logic       e;
    logic       z;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] res, input logic e,
                            input logic z, input logic done, input logic err,
                            input logic busy);
    check({tag, ".result"}, 32'(bus.result), 32'(res));
    check({tag, ".e"},      32'(bus.e),      32'(e));
    check({tag, ".z"},      32'(bus.z),      32'(z));
    check({tag, ".done"},   32'(bus.done),   32'(done));
    check({tag, ".err"},    32'(bus.err),    32'(err));
    check({tag, ".busy"},   32'(bus.busy),   32'(busy));
  endtask

  task automatic issue(input logic [2:0] mode, input logic [7:0] ac, input logic [7:0] dr);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = mode;
    bus.ac    = ac;
    bus.dr    = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.ac    = 8'hA5;
    bus.dr    = 8'h5A;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw_done;
    n_vec = 0;
    n_err = 0;
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.ac    = '0;
    bus.dr    = '0;

    //             mode    ac     dr     res    e     z     err
    vecs.push_back('{3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0}); // ADD with carry
    vecs.push_back('{3'b110, 8'h00, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0}); // NEG 0
    vecs.push_back('{3'b001, 8'h00, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0}); // SHL
    vecs.push_back('{3'b011, 8'h00, 8'h81, 8'h40, 1'b1, 1'b0, 1'b0}); // SHR
    vecs.push_back('{3'b010, 8'h0F, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0}); // XNOR
    vecs.push_back('{3'b111, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b0, 1'b1}); // illegal, held
    vecs.push_back('{3'b100, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0}); // LOAD 0
    vecs.push_back('{3'b000, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0}); // ADD wrap to 0
    vecs.push_back('{3'b111, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1}); // illegal, held
    vecs.push_back('{3'b100, 8'h00, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0}); // LOAD
    vecs.push_back('{3'b010, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0}); // XNOR to 0
    vecs.push_back('{3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0}); // SHR to 0
    vecs.push_back('{3'b001, 8'hFF, 8'h40, 8'h80, 1'b0, 1'b0, 1'b0}); // SHL no carry
    vecs.push_back('{3'b110, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0}); // NEG 1
`ifndef ALU_SEQ_MUL_EN
    vecs.push_back('{3'b101, 8'h10, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b1}); // MUL absent: illegal
`endif

    // Reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      saw_done |= bus.done;
    end
    check("reset_no_done", 32'(saw_done), 32'd0);

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].mode, vecs[i].ac, vecs[i].dr);
      check_outs($sformatf("vec%0d", i), vecs[i].res, vecs[i].e, vecs[i].z, 1'b1,
                 vecs[i].err, 1'b0);
      idle_cycle();
      check_outs($sformatf("vec%0d_after", i), vecs[i].res, vecs[i].e, vecs[i].z, 1'b0,
                 1'b0, 1'b0);
    end

    // Back-to-back LOADs
    issue(3'b100, 8'h00, 8'h00);
    check_outs("b2b_0", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(3'b100, 8'h00, 8'h55);
    check_outs("b2b_1", 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    check("b2b_done_low", 32'(bus.done), 32'd0);

`ifdef ALU_SEQ_MUL_EN
    // MUL 0x10 * 0x11 = 0x110; a competing start stays asserted throughout
    issue(3'b101, 8'h10, 8'h11);
    check_outs("mul_k", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 3'b100;
      bus.ac    = 8'hEE;
      bus.dr    = 8'hEE;
      @(posedge clk);
      #1;
      check_outs($sformatf("mul_k%0d", i), 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(posedge clk);
    #1;
    check_outs("mul_done", 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    check_outs("mul_after", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort: reset during the 4th busy cycle of a MUL
    issue(3'b101, 8'h03, 8'h05);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    check("abort_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("abort_rst", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(posedge clk);
      #1;
      saw_done |= bus.done;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check_outs("abort_final", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
